seq1101_framer_tx: RTL

Serial frame transmitter that produces the bit stream consumed by the team's 1101 Moore sequence detectors. Each parallel word accepted over a valid/ready handshake goes out serially, one bit per clock, in this order: the sync word 1101, the payload MSB-first with zero-stuffing, then two guard zeros. As a result, the line contains 1101 only at a sync position. The block sits between the word source and the serial line; the receive side performs the matching de-stuffing.

---
 rtl/seq1101_pkg.sv | 25 ++
 rtl/seq1101_framer_tx_bit_stuff_ctrl.sv | 31 +++
 rtl/seq1101_framer_tx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seq1101_pkg.sv
// Shared definitions for the 1101 framing transmitter and its matching
// receiver / de-stuffer. Holds the sync word, the stuffing trigger pattern,
// the guard length and the framer state encoding.
package seq1101_pkg;

  // Sync word sent MSB first at the start of every frame.
  localparam logic [3:0] SYNC_WORD = 4'b1101;

  // When the last three line bits (oldest..newest) equal this pattern, a
  // single 0 is stuffed ahead of the next payload bit so 1101 never forms
  // inside the payload.
  localparam logic [2:0] STUFF_PAT = 3'b110;

  // Number of trailing zero guard bits per frame.
  localparam int GUARD_LEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    GUARD
  } state_t;

endpackage

// File: rtl/seq1101_framer_tx_bit_stuff_ctrl.sv
// bit_stuff_ctrl: tracks the last three bits placed on the serial line and
// flags when the next payload bit must be preceded by a stuffed 0.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset (history clears to 000)
//   bit_in    bit that appears on the line for the coming cycle
//   stuff_req high while the history equals STUFF_PAT
module bit_stuff_ctrl
  import seq1101_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  output logic stuff_req
);

  // hist[2] is the oldest bit, hist[0] the bit currently on the line.
  logic [2:0] hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= 3'b000;
    end else begin
      hist <= {hist[1:0], bit_in};
    end
  end

  assign stuff_req = (hist == STUFF_PAT);

endmodule

// File: rtl/seq1101_framer_tx.sv
// seq1101_framer_tx: serial frame transmitter for the 1101 sequence-detector
// link. Each accepted word is sent as: sync word 1101, the payload MSB first
// with zero-stuffing after every 110, then GUARD_LEN zero guard bits.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   in_valid    source offers a word
//   in_data     payload word (captured only on acceptance)
//   in_ready    high only while IDLE
//   y           registered serial line bit
//   busy        high from acceptance until the last guard bit ends
//   frame_done  one-cycle pulse during the last guard bit
module seq1101_framer_tx
  import seq1101_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              y,
  output logic              busy,
  output logic              frame_done
);

  localparam int             CW         = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]  BIT_LAST   = CW'(DATA_W);
  localparam logic [CW-1:0]  BIT_ONE    = CW'(1);
  localparam logic [1:0]     SYNC_LAST  = 2'd3;
  localparam logic [1:0]     GUARD_LAST = 2'(GUARD_LEN - 1);

  // The state register always describes the bit currently driven on y.
  state_t            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;          // index inside SYNC / GUARD
  logic [CW-1:0]     bit_cnt, bit_cnt_nxt;  // payload bits already sent
  logic [DATA_W-1:0] sreg, sreg_nxt;        // payload, next bit at MSB
  logic              y_nxt, busy_nxt, done_nxt;
  logic              step;                  // emit next payload slot
  logic              stuff_req;

  // History follows y exactly: it shifts in the same bit that y loads.
  bit_stuff_ctrl u_stuff (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (y_nxt),
    .stuff_req (stuff_req)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    sreg_nxt    = sreg;
    y_nxt       = 1'b0;
    step        = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt   = SYNC;
          cnt_nxt     = 2'd0;
          bit_cnt_nxt = '0;
          sreg_nxt    = in_data;
          y_nxt       = SYNC_WORD[SYNC_LAST];
        end
      end
      SYNC: begin
        if (cnt == SYNC_LAST) begin
          step = 1'b1;
        end else begin
          cnt_nxt = cnt + 2'd1;
          y_nxt   = SYNC_WORD[SYNC_LAST - cnt_nxt];
        end
      end
      DATA: begin
        if (bit_cnt == BIT_LAST) begin
          // No stuffing after the final payload bit; the guard zeros
          // already break any trailing 110.
          state_nxt = GUARD;
          cnt_nxt   = 2'd0;
        end else begin
          step = 1'b1;
        end
      end
      STUFF: begin
        // A stuff bit is always followed directly by the data bit it
        // protected, never by another stuff bit.
        state_nxt   = DATA;
        y_nxt       = sreg[DATA_W-1];
        sreg_nxt    = {sreg[DATA_W-2:0], 1'b0};
        bit_cnt_nxt = bit_cnt + BIT_ONE;
      end
      GUARD: begin
        if (cnt == GUARD_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Next payload slot: a stuffed 0 when the line history reads 110,
    // otherwise the next payload bit (which alone advances bit_cnt).
    if (step) begin
      if (stuff_req) begin
        state_nxt = STUFF;
        y_nxt     = 1'b0;
      end else begin
        state_nxt   = DATA;
        y_nxt       = sreg[DATA_W-1];
        sreg_nxt    = {sreg[DATA_W-2:0], 1'b0};
        bit_cnt_nxt = bit_cnt + BIT_ONE;
      end
    end

    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == GUARD) && (cnt_nxt == GUARD_LAST);
  end

  // Control and line registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      bit_cnt    <= '0;
      y          <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      y          <= y_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

  // Payload shift register carries data only; every frame reloads it.
  always_ff @(posedge clk) begin
    sreg <= sreg_nxt;
  end

  assign in_ready = (state == IDLE);

endmodule
